// File: rtl/uart_tx_16x.sv
// uart_tx_16x: oversampled UART transmitter, LSB-first frame with optional parity and 1-2 stop bits
module uart_tx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_16x_i,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] tick_q, tick_d;
  logic par_q, par_d;
  logic stop_q, stop_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cell_end;
  assign cell_end = baud_tick_16x_i && tick_q == TICK_LAST;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    par_d = par_q;
    stop_d = stop_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    tick_d = (state_q != IDLE && baud_tick_16x_i) ? (cell_end ? '0 : tick_q + 1'b1) : tick_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        busy_d = 1'b0;
        if (tx_start_i) begin
          shift_d = tx_data_i;
          par_d = (^tx_data_i) ^ 1'(PARITY_ODD);
          tick_d = '0;
          tx_d = 1'b0;
          busy_d = 1'b1;
          state_d = START;
        end
      end
      START: if (cell_end) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = shift_q[0];
      end
      DATA: if (cell_end) begin
        if (bit_q != BIT_LAST) begin
          bit_d = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d = shift_q[1];
        end else if (PARITY_EN != 0) begin
          state_d = PARITY;
          tx_d = par_q;
        end else begin
          state_d = STOP;
          stop_d = 1'b0;
          tx_d = 1'b1;
        end
      end
      PARITY: if (cell_end) begin
        state_d = STOP;
        stop_d = 1'b0;
        tx_d = 1'b1;
      end
      STOP: if (cell_end) begin
        if (stop_q == STOP_LAST) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else stop_d = 1'b1;
        tx_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tick_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tick_q <= tick_d;
      par_q <= par_d;
      stop_q <= stop_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx_o = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;
endmodule
